// File: rtl/seg_pkg.sv
// Shared types and constants for the 8-digit seven-segment scan controller.
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] digit_t;

  typedef enum logic {
    SCAN_BLANK,
    SCAN_DRIVE
  } scan_state_e;

  // Active-low segments: all ones means every segment is dark.
  localparam seg_t SEG_OFF = 7'h7F;

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex-to-seven-segment decoder, active-low, bit 6 = A ... bit 0 = G.
module hex7seg_dec
  import seg_pkg::*;
(
  input  digit_t i_digit,
  output seg_t   o_seg
);

  // Standard hex glyphs; lower-case b and d keep them distinct from 8 and 0.
  always_comb begin
    o_seg = SEG_OFF;
    unique case (i_digit)
      4'h0: o_seg = 7'b0000001;
      4'h1: o_seg = 7'b1001111;
      4'h2: o_seg = 7'b0010010;
      4'h3: o_seg = 7'b0000110;
      4'h4: o_seg = 7'b1001100;
      4'h5: o_seg = 7'b0100100;
      4'h6: o_seg = 7'b0100000;
      4'h7: o_seg = 7'b0001111;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0000100;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b1100000;
      4'hC: o_seg = 7'b0110001;
      4'hD: o_seg = 7'b1000010;
      4'hE: o_seg = 7'b0110000;
      4'hF: o_seg = 7'b0111000;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit, 7-segment display with
// per-slot blanking, a digit-enable mask and registered active-low outputs.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned TICKS_PER_DIGIT = 100000,
  parameter int unsigned BLANK_TICKS     = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       mask_wr,
  input  logic [7:0] mask_data,
  output logic [6:0] seg,
  output logic [7:0] an,
  output logic       frame_done
);

  localparam int unsigned TickW = $clog2(TICKS_PER_DIGIT);
  localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_DIGIT - 1);
  localparam bit HasBlank = (BLANK_TICKS != 0);
  localparam logic [TickW-1:0] BlankLast = HasBlank ? TickW'(BLANK_TICKS - 1) : '0;

  digit_t           r_buf [NUM_DIGITS];
  logic [7:0]       r_mask;
  logic [2:0]       r_idx;
  logic [TickW-1:0] r_tick;
  scan_state_e      r_state;
  scan_state_e      w_state_d;
  seg_t             r_seg;
  logic [7:0]       r_an;
  logic             r_frame_done;

  logic             w_slot_end;
  logic             w_showing;
  seg_t             w_dec;
  seg_t             w_seg_d;
  logic [7:0]       w_an_d;

  assign w_slot_end = (r_tick == TickLast);

  hex7seg_dec u_dec (
    .i_digit (r_buf[r_idx]),
    .o_seg   (w_dec)
  );

  // Digit buffer and enable mask; the two write ports are independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_buf[i] <= '0;
      end
      r_mask <= 8'hFF;
    end else begin
      if (wr_en) begin
        r_buf[wr_addr] <= wr_data;
      end
      if (mask_wr) begin
        r_mask <= mask_data;
      end
    end
  end

  // Slot tick counter and digit index; masked digits still take a full slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick <= '0;
      r_idx  <= '0;
    end else if (w_slot_end) begin
      r_tick <= '0;
      r_idx  <= r_idx + 3'd1;
    end else begin
      r_tick <= r_tick + TickW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SCAN_BLANK;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next state: blank for the first BLANK_TICKS cycles of a slot, then drive.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      SCAN_BLANK: begin
        if (!HasBlank || w_slot_end || (r_tick == BlankLast)) begin
          w_state_d = SCAN_DRIVE;
        end
      end
      SCAN_DRIVE: begin
        if (w_slot_end) begin
          w_state_d = HasBlank ? SCAN_BLANK : SCAN_DRIVE;
        end
      end
      default: w_state_d = SCAN_BLANK;
    endcase
  end

  // Output decode for the current slot cycle; with no blanking the single
  // post-reset BLANK cycle is shown as a drive cycle.
  always_comb begin
    w_an_d    = 8'hFF;
    w_seg_d   = SEG_OFF;
    w_showing = (r_state == SCAN_DRIVE) || !HasBlank;
    if (w_showing) begin
      w_seg_d = w_dec;
      if (r_mask[r_idx]) begin
        w_an_d = ~(8'h01 << r_idx);
      end
    end
  end

  // Registered outputs, lagging the scan state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an         <= 8'hFF;
      r_seg        <= SEG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_d;
      r_seg        <= w_seg_d;
      r_frame_done <= w_slot_end && (r_idx == 3'd7);
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: one instance with blanking, one without.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       mask_wr;
  logic [7:0] mask_data;
  logic [6:0] seg, seg_nb;
  logic [7:0] an, an_nb;
  logic       frame_done, frame_done_nb;

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  logic [3:0] m_buf [8];
  logic [7:0] m_mask;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.TICKS_PER_DIGIT(8), .BLANK_TICKS(2)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mask_wr    (mask_wr),
    .mask_data  (mask_data),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  seg_scan_ctrl #(.TICKS_PER_DIGIT(8), .BLANK_TICKS(0)) u_dut_nb (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mask_wr    (mask_wr),
    .mask_data  (mask_data),
    .seg        (seg_nb),
    .an         (an_nb),
    .frame_done (frame_done_nb)
  );

  function automatic logic [6:0] f_dec(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'b0000001;  4'h1: r = 7'b1001111;
      4'h2: r = 7'b0010010;  4'h3: r = 7'b0000110;
      4'h4: r = 7'b1001100;  4'h5: r = 7'b0100100;
      4'h6: r = 7'b0100000;  4'h7: r = 7'b0001111;
      4'h8: r = 7'b0000000;  4'h9: r = 7'b0000100;
      4'hA: r = 7'b0001000;  4'hB: r = 7'b1100000;
      4'hC: r = 7'b0110001;  4'hD: r = 7'b1000010;
      4'hE: r = 7'b0110000;  default: r = 7'b0111000;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] f_an(input int c, input int blank);
    int d = (c / 8) % 8;
    int t = c % 8;
    if (t < blank || !m_mask[d]) return 8'hFF;
    return ~(8'h01 << d);
  endfunction

  function automatic logic [6:0] f_seg(input int c, input int blank);
    int d = (c / 8) % 8;
    int t = c % 8;
    if (t < blank) return 7'h7F;
    return f_dec(m_buf[d]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_buf[i] = 4'h0;
    m_mask = 8'hFF;
  endtask

  task automatic test_reset();
    logic [7:0] ea;
    logic [6:0] es;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; mask_wr = 1'b0; mask_data = '0;
    cyc = 0;
    repeat (3) step();
    n_vec++;
    if ({an, seg, frame_done} !== {8'hFF, 7'h7F, 1'b0}) begin
      n_err++;
      $display("FAIL reset_outputs: got an=%h seg=%b fd=%b want an=ff seg=1111111 fd=0",
               an, seg, frame_done);
    end
    n_vec++;
    if ({an_nb, seg_nb, frame_done_nb} !== {8'hFF, 7'h7F, 1'b0}) begin
      n_err++;
      $display("FAIL reset_outputs_nb: got an=%h seg=%b fd=%b want an=ff seg=1111111 fd=0",
               an_nb, seg_nb, frame_done_nb);
    end
    rst = 1'b0;
    model_reset();
    cyc = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      ea = (cyc >= 2 && cyc <= 7) ? 8'hFE : 8'hFF;
      es = (cyc >= 2 && cyc <= 7) ? 7'b0000001 : 7'h7F;
      n_vec++;
      if (an !== ea || seg !== es) begin
        n_err++;
        $display("FAIL first_slot cyc=%0d: got an=%h seg=%b want an=%h seg=%b",
                 cyc, an, seg, ea, es);
      end
      ea = (cyc < 8) ? 8'hFE : 8'hFD;
      n_vec++;
      if (an_nb !== ea) begin
        n_err++;
        $display("FAIL first_slot_nb cyc=%0d: got an=%h want an=%h", cyc, an_nb, ea);
      end
    end
  endtask

  task automatic test_digit_write();
    logic [7:0] ea;
    logic [6:0] es;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hA;
    step();
    wr_en = 1'b0;
    m_buf[3] = 4'hA;
    while (cyc < 31) begin
      step();
      if (cyc >= 24) begin
        ea = (cyc >= 26) ? 8'hF7 : 8'hFF;
        es = (cyc >= 26) ? 7'b0001000 : 7'h7F;
        n_vec++;
        if (an !== ea || seg !== es) begin
          n_err++;
          $display("FAIL slot3_digit_a cyc=%0d: got an=%h seg=%b want an=%h seg=%b",
                   cyc, an, seg, ea, es);
        end
      end
    end
  endtask

  task automatic test_frame_done();
    logic ef;
    while (cyc < 130) begin
      step();
      ef = (cyc % 64 == 63);
      n_vec++;
      if (frame_done !== ef || frame_done_nb !== ef || an !== f_an(cyc, 2)) begin
        n_err++;
        $display("FAIL frame_done cyc=%0d: got fd=%b fd_nb=%b an=%h want fd=%b an=%h",
                 cyc, frame_done, frame_done_nb, an, ef, f_an(cyc, 2));
      end
    end
  endtask

  task automatic test_mask();
    logic ef;
    mask_wr = 1'b1; mask_data = 8'hDF;
    step();
    mask_wr = 1'b0;
    m_mask = 8'hDF;
    while (cyc < 191) begin
      step();
      ef = (cyc % 64 == 63);
      n_vec++;
      if (an !== f_an(cyc, 2) || seg !== f_seg(cyc, 2) || frame_done !== ef) begin
        n_err++;
        $display("FAIL mask_scan cyc=%0d: got an=%h seg=%b fd=%b want an=%h seg=%b fd=%b",
                 cyc, an, seg, frame_done, f_an(cyc, 2), f_seg(cyc, 2), ef);
      end
      n_vec++;
      if (an_nb !== f_an(cyc, 0)) begin
        n_err++;
        $display("FAIL mask_scan_nb cyc=%0d: got an=%h want an=%h", cyc, an_nb, f_an(cyc, 0));
      end
      if (cyc == 172 || cyc == 178) begin
        n_vec++;
        if (an !== ((cyc == 172) ? 8'hFF : 8'hBF)) begin
          n_err++;
          $display("FAIL mask_slot cyc=%0d: got an=%h want an=%h",
                   cyc, an, (cyc == 172) ? 8'hFF : 8'hBF);
        end
      end
    end
  endtask

  task automatic test_live_write();
    while (cyc < 194) step();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'hF;
    step();
    wr_en = 1'b0;
    n_vec++;
    if (an !== 8'hFE || seg !== 7'b0000001) begin
      n_err++;
      $display("FAIL live_write_edge_k: got an=%h seg=%b want an=fe seg=0000001", an, seg);
    end
    step();
    m_buf[0] = 4'hF;
    n_vec++;
    if (an !== 8'hFE || seg !== 7'b0111000) begin
      n_err++;
      $display("FAIL live_write_edge_k1: got an=%h seg=%b want an=fe seg=0111000", an, seg);
    end
  endtask

  task automatic test_mid_reset();
    logic ef;
    while (cyc < 229) step();
    n_vec++;
    if (an !== 8'hEF) begin
      n_err++;
      $display("FAIL pre_reset_slot4: got an=%h want an=ef", an);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if ({an, seg, frame_done} !== {8'hFF, 7'h7F, 1'b0}) begin
      n_err++;
      $display("FAIL mid_reset: got an=%h seg=%b fd=%b want an=ff seg=1111111 fd=0",
               an, seg, frame_done);
    end
    model_reset();
    cyc = -1;
    while (cyc < 69) begin
      step();
      ef = (cyc % 64 == 63);
      n_vec++;
      if (an !== f_an(cyc, 2) || seg !== f_seg(cyc, 2) || frame_done !== ef) begin
        n_err++;
        $display("FAIL restart cyc=%0d: got an=%h seg=%b fd=%b want an=%h seg=%b fd=%b",
                 cyc, an, seg, frame_done, f_an(cyc, 2), f_seg(cyc, 2), ef);
      end
      n_vec++;
      if (an_nb !== f_an(cyc, 0) || seg_nb !== f_seg(cyc, 0) || frame_done_nb !== ef) begin
        n_err++;
        $display("FAIL blank_zero cyc=%0d: got an=%h seg=%b fd=%b want an=%h seg=%b fd=%b",
                 cyc, an_nb, seg_nb, frame_done_nb, f_an(cyc, 0), f_seg(cyc, 0), ef);
      end
      if (cyc == 26) begin
        n_vec++;
        if (an !== 8'hF7 || seg !== 7'b0000001) begin
          n_err++;
          $display("FAIL digit3_cleared: got an=%h seg=%b want an=f7 seg=0000001", an, seg);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 4'hB;
    mask_wr = 1'b1; mask_data = 8'h7F;
    step();
    wr_en = 1'b0; mask_wr = 1'b0;
    m_buf[7] = 4'hB;
    m_mask = 8'h7F;
    while (cyc < 127) begin
      step();
      n_vec++;
      if (an !== f_an(cyc, 2) || seg !== f_seg(cyc, 2) || an_nb !== f_an(cyc, 0)) begin
        n_err++;
        $display("FAIL dual_write cyc=%0d: got an=%h seg=%b an_nb=%h want an=%h seg=%b an_nb=%h",
                 cyc, an, seg, an_nb, f_an(cyc, 2), f_seg(cyc, 2), f_an(cyc, 0));
      end
      if (cyc == 122) begin
        n_vec++;
        if (an !== 8'hFF || seg !== 7'b1100000) begin
          n_err++;
          $display("FAIL dual_write_slot7: got an=%h seg=%b want an=ff seg=1100000", an, seg);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_digit_write();
    test_frame_done();
    test_mask();
    test_live_write();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
